// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types for the DDR port arbiter: FSM states, timeout fill value and
// the request snapshot taken when a requester is granted.
package ddr_arb_pkg;

    localparam int ADDR_W_C = 32;
    localparam int DATA_W_C = 32;

    localparam logic [DATA_W_C-1:0] DEADBEEF_C = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W_C-1:0]   addr;
        logic [DATA_W_C-1:0]   wdata;
        logic [DATA_W_C/8-1:0] wstrb;
        logic                  id;
    } arb_req_t;

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// PicoRV32-native style memory port. The requester drives the master side,
// the arbiter consumes the slave side.
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic [DATA_W-1:0]   rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/ddr_port_arbiter_rr.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module ddr_arb_rr (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic rr_last_i,
    output logic any_o,
    output logic grant_o
);

    // Pick the single requester, or alternate away from rr_last on a tie.
    always_comb begin
        any_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            grant_o = ~rr_last_i;
        end else begin
            grant_o = valid1_i;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Serialises two requesters onto the single DDR model port, one transaction
// at a time, with a response watchdog so nobody hangs on a missing reply.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no transaction; arbitrate and snapshot the winner's request
//   ISSUE    | one-cycle DDR strobe; watchdog cleared
//   WAIT     | waiting for the matching DDR response or watchdog expiry
//   DONE     | one-cycle ready pulse to the owner; round-robin pointer moves
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_C,
    parameter int DATA_W  = DATA_W_C,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                resetn,
    ddr_port_arbiter_if.slave   m0,
    ddr_port_arbiter_if.slave   m1,
    output logic                ddr_rd_req,
    output logic                ddr_wr_req,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic [DATA_W-1:0]   ddr_wr_data,
    output logic [DATA_W/8-1:0] ddr_wr_strb,
    input  logic                ddr_rd_valid,
    input  logic [DATA_W-1:0]   ddr_rd_data,
    input  logic                ddr_wr_ack,
    output logic                grant_id,
    output logic                busy,
    output logic                timeout_err
);

    localparam logic [15:0] TMO_C = 16'(TIMEOUT);

    arb_state_e        state_q, state_d;
    arb_req_t          req_q, req_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rr_last_q, rr_last_d;
    logic              terr_q, terr_d;

    logic rr_any, rr_grant;
    logic is_read, rsp_match;

    ddr_arb_rr u_rr (
        .valid0_i  (m0.valid),
        .valid1_i  (m1.valid),
        .rr_last_i (rr_last_q),
        .any_o     (rr_any),
        .grant_o   (rr_grant)
    );

    assign is_read   = (req_q.wstrb == '0);
    assign rsp_match = is_read ? ddr_rd_valid : ddr_wr_ack;

    // State and datapath registers; rr_last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            rr_last_q <= 1'b1;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rr_last_q <= rr_last_d;
            terr_q    <= terr_d;
        end
    end

    // Next-state logic; responses outside ISSUE/WAIT are ignored by construction.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rr_last_d = rr_last_q;
        terr_d    = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    req_d.addr  = rr_grant ? m1.addr  : m0.addr;
                    req_d.wdata = rr_grant ? m1.wdata : m0.wdata;
                    req_d.wstrb = rr_grant ? m1.wstrb : m0.wstrb;
                    req_d.id    = rr_grant;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
                if (rsp_match) begin
                    if (is_read) rdata_d = ddr_rd_data;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_match) begin
                    if (is_read) rdata_d = ddr_rd_data;
                    state_d = ST_DONE;
                end else if (cnt_q == TMO_C) begin
                    rdata_d = DEADBEEF_C;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                rr_last_d = req_q.id;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched request.
    always_comb begin
        ddr_rd_req  = (state_q == ST_ISSUE) &&  is_read;
        ddr_wr_req  = (state_q == ST_ISSUE) && !is_read;
        ddr_addr    = req_q.addr;
        ddr_wr_data = req_q.wdata;
        ddr_wr_strb = req_q.wstrb;
        m0.ready    = (state_q == ST_DONE) && !req_q.id;
        m1.ready    = (state_q == ST_DONE) &&  req_q.id;
        m0.rdata    = rdata_q;
        m1.rdata    = rdata_q;
        grant_id    = req_q.id;
        busy        = (state_q != ST_IDLE);
        timeout_err = terr_q;
    end

endmodule

// File: doc/ddr_port_arbiter.md
# ddr_port_arbiter

Arbitrates the single DDR model port (ddr_rd_req / ddr_wr_req / ddr_addr / ddr_rd_valid / ddr_rd_data) between two PicoRV32-native-style requesters: port 0 (CPU) and port 1 (DMA/loader). It sits in top_picorv32_system between the core memory interface and ddr_inst. It serialises one transaction at a time with round-robin fairness. A response watchdog guarantees a requester is never hung by a missing DDR reply.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max WAIT cycles before forced completion (1..65535)
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- mN_valid  in  1  requester N (N=0,1) transaction request, held until mN_ready
- mN_addr  in  ADDR_W  requester N byte address
- mN_wdata  in  DATA_W  requester N write data
- mN_wstrb  in  DATA_W/8  byte enables; all-zero = read, nonzero = write
- mN_ready  out  1  one-cycle completion pulse to requester N
- mN_rdata  out  DATA_W  read data, valid when mN_ready=1
- ddr_rd_req / ddr_wr_req  out  1  one-cycle DDR read / write strobe
- ddr_addr  out  ADDR_W  DDR address, stable from ISSUE through response
- ddr_wr_data  out  DATA_W  DDR write data
- ddr_wr_strb  out  DATA_W/8  DDR byte enables
- ddr_rd_valid  in  1  DDR read data valid pulse
- ddr_rd_data  in  DATA_W  DDR read data
- ddr_wr_ack  in  1  DDR write completion pulse
- grant_id  out  1  requester owning the current transaction
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky: set on any watchdog expiry, cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if neither valid, stay. If exactly one valid, grant it. If both valid, grant the port not granted last (rr_last). The transaction's addr, wdata, wstrb and id are latched into registers, then go to ISSUE.
- ISSUE (exactly 1 cycle): assert ddr_rd_req if latched wstrb==0, else ddr_wr_req. Clear the watchdog counter. Go to WAIT, or directly to DONE if the matching response arrives this same cycle.
- WAIT: count cycles. A matching response (ddr_rd_valid for reads, ddr_wr_ack for writes) captures rdata (reads only) and goes to DONE. If the counter reaches TIMEOUT with no response, go to DONE with rdata=32'hDEAD_BEEF and set timeout_err.
- DONE (1 cycle): pulse m[grant_id]_ready with captured rdata, update rr_last=grant_id, return to IDLE.
- Non-matching responses, and any response in IDLE/DONE (late replies after timeout), are ignored.
- A requester dropping valid mid-transaction does not abort it. The DDR access completes and ready is still pulsed.
- mN_rdata is the shared captured register. It is only meaningful while mN_ready=1.

## Timing
- Reset values: all outputs 0; state=IDLE; rr_last=1, so port 0 wins the first tie; counter=0.
- Valid sampled in IDLE at cycle T. ISSUE at T+1. Response at cycle R (R ≥ T+1). Ready at R+1. IDLE at R+2.
- Minimum latency is valid to ready = 2 cycles.
- At least 1 idle cycle separates back-to-back grants (DONE → IDLE → ISSUE).
- Timeout: ready is asserted TIMEOUT+2 cycles after ISSUE.
- Reset asserted mid-transaction: immediate return to IDLE, with no ready pulse and no DDR strobe.

## Structure
- Package ddr_arb_pkg: state enum, DEADBEEF_C constant, and the latched request struct (addr, wdata, wstrb, id).
- Sub-module ddr_arb_rr: 2-way round-robin picker (valids and rr_last in, grant out), combinational.

## Test plan
- Port 0 read of addr 0x10 (mem=0x00000013), DDR responds 3 cycles after req → single ddr_rd_req, ddr_addr=0x10, m0_ready 1 cycle later with rdata=0x00000013, m1_ready never asserted.
- Both valid every cycle for 6 transactions → grants strictly alternate 0,1,0,1,0,1, starting with port 0.
- Port 1 write 0xCAFEF00D, wstrb=4'b0011, to 0x40 → ddr_wr_req with matching data/strb, m1_ready after ddr_wr_ack, and the DDR model holds the low halfword only.
- Read with no DDR response, TIMEOUT=8 → m0_ready exactly 10 cycles after ISSUE, rdata=0xDEADBEEF, timeout_err=1. A late ddr_rd_valid afterwards has no effect.
- ddr_rd_valid in the same cycle as ddr_rd_req → ready in the next cycle (2-cycle min latency).
- resetn pulled low while in WAIT → all outputs 0 asynchronously, and no ready pulse after release.
